// File: rtl/thread_scheduler_if.sv
// Fetch-scheduler bus: thread status/requests from the pipeline, grant and
// exception-entry pulses back to stage_if.
interface thread_scheduler_if #(
  parameter int unsigned N_THREADS = 8,
  parameter int unsigned TID_W     = $clog2(N_THREADS)
);
  logic [N_THREADS-1:0] stalled;
  logic                 hold;
  logic                 imiss_en;
  logic [TID_W-1:0]     imiss_thread;
  logic                 ifill_en;
  logic                 retire_en;
  logic [TID_W-1:0]     retire_thread;
  logic                 exc_req_en;
  logic [TID_W-1:0]     exc_req_thread;
  logic                 sched_en;
  logic [TID_W-1:0]     sched_thread;
  logic                 exc_en;
  logic [TID_W-1:0]     exc_thread;
  logic [N_THREADS-1:0] busy;

  modport master (
    output stalled, hold, imiss_en, imiss_thread, ifill_en,
           retire_en, retire_thread, exc_req_en, exc_req_thread,
    input  sched_en, sched_thread, exc_en, exc_thread, busy
  );

  modport slave (
    input  stalled, hold, imiss_en, imiss_thread, ifill_en,
           retire_en, retire_thread, exc_req_en, exc_req_thread,
    output sched_en, sched_thread, exc_en, exc_thread, busy
  );
endinterface

// File: rtl/thread_scheduler.sv
// Per-cycle round-robin fetch-thread selector with per-thread in-flight caps,
// i-miss parking and exception drain/entry sequencing.
module thread_scheduler #(
  parameter int unsigned N_THREADS    = 8,
  parameter int unsigned MAX_INFLIGHT = 6,
  parameter int unsigned TID_W        = $clog2(N_THREADS)
) (
  input logic               clk,
  input logic               rst,
  thread_scheduler_if.slave bus
);
  typedef enum logic [1:0] {ST_RUN, ST_IMISS, ST_EXC} state_e;

  state_e               r_state        [N_THREADS];
  state_e               w_state_nxt    [N_THREADS];
  logic [3:0]           r_inflight     [N_THREADS];
  logic [3:0]           w_inflight_nxt [N_THREADS];
  logic [TID_W-1:0]     r_rr, w_rr_nxt;
  logic                 r_sched_en, w_sched_en_nxt;
  logic [TID_W-1:0]     r_sched_thread, w_sched_thread_nxt;
  logic                 r_exc_en, w_exc_en_nxt;
  logic [TID_W-1:0]     r_exc_thread, w_exc_thread_nxt;
  logic [N_THREADS-1:0] w_imiss_hit, w_exc_hit, w_ret_hit, w_elig;
  logic [N_THREADS-1:0] w_grant_hit, w_exc_sel, w_busy;
  logic [TID_W-1:0]     w_idx;

  always_comb begin
    w_imiss_hit        = '0;
    w_exc_hit          = '0;
    w_ret_hit          = '0;
    w_elig             = '0;
    w_grant_hit        = '0;
    w_exc_sel          = '0;
    w_idx              = '0;
    w_rr_nxt           = r_rr;
    w_sched_en_nxt     = 1'b0;
    w_sched_thread_nxt = r_sched_thread;
    w_exc_en_nxt       = 1'b0;
    w_exc_thread_nxt   = r_exc_thread;

    for (int unsigned i = 0; i < N_THREADS; i++) begin
      w_imiss_hit[i] = bus.imiss_en && (bus.imiss_thread == TID_W'(i));
      w_exc_hit[i]   = bus.exc_req_en && (bus.exc_req_thread == TID_W'(i));
      // A retire against an empty counter is dropped rather than wrapping.
      w_ret_hit[i]   = bus.retire_en && (bus.retire_thread == TID_W'(i)) &&
                       (r_inflight[i] != 4'd0);
      w_elig[i]      = (r_state[i] == ST_RUN) && !bus.stalled[i] &&
                       (r_inflight[i] < 4'(MAX_INFLIGHT)) &&
                       !w_imiss_hit[i] && !w_exc_hit[i] && !bus.hold;
    end

    // Scan starts one past the pointer; k == N_THREADS wraps back onto it.
    for (int unsigned k = 1; k <= N_THREADS; k++) begin
      w_idx = r_rr + TID_W'(k);
      if (!w_sched_en_nxt && w_elig[w_idx]) begin
        w_sched_en_nxt     = 1'b1;
        w_sched_thread_nxt = w_idx;
        w_rr_nxt           = w_idx;
      end
    end
    if (w_sched_en_nxt)
      w_grant_hit[w_sched_thread_nxt] = 1'b1;

    for (int unsigned i = 0; i < N_THREADS; i++) begin
      if (!w_exc_en_nxt && (r_state[i] == ST_EXC) &&
          ((r_inflight[i] - {3'b000, w_ret_hit[i]}) == 4'd0)) begin
        w_exc_en_nxt     = 1'b1;
        w_exc_thread_nxt = TID_W'(i);
        w_exc_sel[i]     = 1'b1;
      end
    end

    for (int unsigned i = 0; i < N_THREADS; i++) begin
      w_busy[i]         = (r_state[i] != ST_RUN);
      w_inflight_nxt[i] = r_inflight[i];
      if (w_grant_hit[i] && !w_ret_hit[i])
        w_inflight_nxt[i] = r_inflight[i] + 4'd1;
      else if (!w_grant_hit[i] && w_ret_hit[i])
        w_inflight_nxt[i] = r_inflight[i] - 4'd1;

      w_state_nxt[i] = r_state[i];
      if (w_exc_hit[i] && (r_state[i] != ST_EXC)) begin
        w_state_nxt[i] = ST_EXC;
      end else begin
        case (r_state[i])
          ST_RUN:   if (w_imiss_hit[i]) w_state_nxt[i] = ST_IMISS;
          ST_IMISS: if (bus.ifill_en)   w_state_nxt[i] = ST_RUN;
          ST_EXC:   if (w_exc_sel[i])   w_state_nxt[i] = ST_RUN;
          default:                      w_state_nxt[i] = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_THREADS; i++) begin
        r_state[i]    <= ST_RUN;
        r_inflight[i] <= '0;
      end
      r_rr           <= TID_W'(N_THREADS - 1);
      r_sched_en     <= 1'b0;
      r_sched_thread <= '0;
      r_exc_en       <= 1'b0;
      r_exc_thread   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_THREADS; i++) begin
        r_state[i]    <= w_state_nxt[i];
        r_inflight[i] <= w_inflight_nxt[i];
      end
      r_rr           <= w_rr_nxt;
      r_sched_en     <= w_sched_en_nxt;
      r_sched_thread <= w_sched_thread_nxt;
      r_exc_en       <= w_exc_en_nxt;
      r_exc_thread   <= w_exc_thread_nxt;
    end
  end

  assign bus.sched_en     = r_sched_en;
  assign bus.sched_thread = r_sched_thread;
  assign bus.exc_en       = r_exc_en;
  assign bus.exc_thread   = r_exc_thread;
  assign bus.busy         = w_busy;
endmodule
